// File: rtl/reg_file_wb.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_wb
// Brief    : Write-back side of the 4-entry register file. Result writes are
//            buffered in an in-order queue and retire one per cycle into the
//            registers. A pending mask lets issue logic stall on RAW hazards.
// Revision : 1.0  initial release
// ============================================================================
module reg_file_wb #(
   parameter int DW      = 4,
   parameter int DEPTH   = 2,
   parameter int R0_ZERO = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       IN_VALID,
   output logic                       IN_READY,
   input  logic [1:0]                 IN_SEL,
   input  logic [DW-1:0]              IN_DATA,
   input  logic                       HOLD,
   output logic [4*DW-1:0]            REGS,
   output logic [3:0]                 PEND,
   output logic [$clog2(DEPTH):0]     CNT,
   output logic                       FULL,
   output logic                       EMPTY
);

   localparam int c_AW = $clog2(DEPTH);
   localparam int c_CW = c_AW + 1;

   // Queue payload and per-slot valid bits
   logic [1:0]      r_q_sel  [DEPTH];
   logic [DW-1:0]   r_q_data [DEPTH];
   logic [DEPTH-1:0] r_q_vld;

   logic [c_AW-1:0] r_head;
   logic [c_AW-1:0] r_tail;
   logic [c_CW-1:0] r_cnt;

   // Goes high on the first clock after reset release; gates IN_READY so
   // that nothing is accepted while reset is held.
   logic            r_live;

   logic [DW-1:0]   r_regs [4];

   logic            w_enq;
   logic            w_deq;
   logic            w_full;
   logic            w_empty;
   logic [1:0]      w_head_sel;
   logic [DW-1:0]   w_head_data;
   logic [3:0]      w_pend;

   assign w_full      = (r_cnt == c_CW'(DEPTH));
   assign w_empty     = (r_cnt == '0);
   assign w_head_sel  = r_q_sel[r_head];
   assign w_head_data = r_q_data[r_head];

   // Ready depends on state only, never on IN_VALID
   assign IN_READY = r_live && !w_full;
   assign w_enq    = IN_VALID && IN_READY;
   // An empty queue never bypasses: a fresh entry retires next edge at best
   assign w_deq    = !w_empty && !HOLD;

   assign CNT   = r_cnt;
   assign FULL  = w_full;
   assign EMPTY = w_empty;

   // Track leaving reset so IN_READY rises on the first clock after release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_live <= 1'b0;
      end else begin
         r_live <= 1'b1;
      end
   end

   // Queue control: pointers, occupancy and slot valid bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_cnt   <= '0;
         r_q_vld <= '0;
      end else begin
         // Head and tail index different slots whenever both fire, since
         // enqueue needs not-full and dequeue needs not-empty.
         if (w_enq) begin
            r_q_vld[r_tail] <= 1'b1;
            r_tail          <= r_tail + 1'b1;
         end
         if (w_deq) begin
            r_q_vld[r_head] <= 1'b0;
            r_head          <= r_head + 1'b1;
         end
         case ({w_enq, w_deq})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Queue payload; contents are qualified by r_q_vld so no reset is needed
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_q_sel[r_tail]  <= IN_SEL;
         r_q_data[r_tail] <= IN_DATA;
      end
   end

   // Register array: retire the head entry; writes to R0 vanish when hardwired
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            r_regs[i] <= DW'(i);
         end
      end else if (w_deq && !((R0_ZERO != 0) && (w_head_sel == 2'd0))) begin
         r_regs[w_head_sel] <= w_head_data;
      end
   end

   // Pending mask: OR of one-hot destinations over all live queue slots
   always_comb begin
      w_pend = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_q_vld[i]) begin
            w_pend[r_q_sel[i]] = 1'b1;
         end
      end
      if (R0_ZERO != 0) begin
         w_pend[0] = 1'b0;
      end
   end

   assign PEND = w_pend;

   generate
      for (genvar g = 0; g < 4; g++) begin : g_regs
         assign REGS[g*DW +: DW] = r_regs[g];
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_reg_file_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_wb
// Brief    : Directed bench for reg_file_wb with a queue-based reference model
//            compared every cycle, plus hand-computed literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_reg_file_wb;

   localparam int DW      = 4;
   localparam int DEPTH   = 2;
   localparam int R0_ZERO = 1;

   logic                   clk;
   logic                   rst_n;
   logic                   in_valid;
   logic                   in_ready;
   logic [1:0]             in_sel;
   logic [DW-1:0]          in_data;
   logic                   hold;
   logic [4*DW-1:0]        regs;
   logic [3:0]             pend;
   logic [$clog2(DEPTH):0] cnt;
   logic                   full;
   logic                   empty;

   int n_checks = 0;
   int n_err    = 0;

   reg_file_wb #(.DW(DW), .DEPTH(DEPTH), .R0_ZERO(R0_ZERO)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .IN_VALID (in_valid),
      .IN_READY (in_ready),
      .IN_SEL   (in_sel),
      .IN_DATA  (in_data),
      .HOLD     (hold),
      .REGS     (regs),
      .PEND     (pend),
      .CNT      (cnt),
      .FULL     (full),
      .EMPTY    (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [1+DW:0] m_q[$];            // {sel, data}, front = oldest
   logic [DW-1:0] m_regs [4];
   bit            m_live;

   // Model state advances on the clock; reset wipes everything at once
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         for (int i = 0; i < 4; i++) m_regs[i] = DW'(i);
         m_live = 0;
      end else begin
         bit rdy, enq, deq;
         logic [1+DW:0] e;
         rdy = m_live && (m_q.size() < DEPTH);
         enq = in_valid && rdy;
         deq = (m_q.size() > 0) && !hold;
         if (deq) begin
            e = m_q.pop_front();
            if (!(R0_ZERO != 0 && e[DW+1:DW] == 2'd0))
               m_regs[e[DW+1:DW]] = e[DW-1:0];
         end
         if (enq) m_q.push_back({in_sel, in_data});
         m_live = 1;
      end
   end

   // Compare every output against the model on the falling edge
   always @(negedge clk) begin
      logic [3:0]      ep;
      logic [4*DW-1:0] er;
      ep = '0;
      foreach (m_q[k]) ep[m_q[k][DW+1:DW]] = 1'b1;
      if (R0_ZERO != 0) ep[0] = 1'b0;
      for (int i = 0; i < 4; i++) er[i*DW +: DW] = m_regs[i];
      check("model_regs",  32'(regs),     32'(er));
      check("model_pend",  32'(pend),     32'(ep));
      check("model_cnt",   32'(cnt),      32'(m_q.size()));
      check("model_full",  32'(full),     32'(m_q.size() == DEPTH));
      check("model_empty", 32'(empty),    32'(m_q.size() == 0));
      check("model_ready", 32'(in_ready), 32'(m_live && m_q.size() < DEPTH));
   end

   // Advance one clock; inputs change 1 time unit after the edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] s, input logic [DW-1:0] d);
      in_valid = v;
      in_sel   = s;
      in_data  = d;
   endtask

   initial begin
      int waited;
      rst_n = 1'b0;
      hold  = 1'b0;
      drive(1'b0, 2'd0, '0);
      repeat (3) cyc();
      check("rst_ready_low", 32'(in_ready), 32'd0);
      rst_n = 1'b1;
      cyc();

      // Reset values
      check("rst_regs",  32'(regs),     32'h3210);
      check("rst_cnt",   32'(cnt),      32'd0);
      check("rst_empty", 32'(empty),    32'd1);
      check("rst_pend",  32'(pend),     32'd0);
      check("rst_ready", 32'(in_ready), 32'd1);

      // Single write to R2
      drive(1'b1, 2'd2, 4'hA);
      cyc();
      drive(1'b0, 2'd0, '0);
      check("single_pend", 32'(pend), 32'b0100);
      check("single_cnt",  32'(cnt),  32'd1);
      cyc();
      check("single_r2",   32'(regs[11:8]), 32'hA);
      check("single_pend0", 32'(pend), 32'd0);

      // Fill with HOLD, then back-pressure a third request
      hold = 1'b1;
      drive(1'b1, 2'd1, 4'h5); cyc();
      drive(1'b1, 2'd3, 4'h7); cyc();
      drive(1'b1, 2'd2, 4'h9);
      check("full_flag",  32'(full),     32'd1);
      check("full_ready", 32'(in_ready), 32'd0);
      check("full_pend",  32'(pend),     32'b1010);
      cyc();
      check("bp_cnt", 32'(cnt), 32'd2);
      hold = 1'b0;
      cyc();
      check("bp_r1",  32'(regs[7:4]), 32'h5);
      check("bp_cnt1", 32'(cnt), 32'd1);
      waited = 0;
      while (!in_ready && waited < 10) begin
         cyc();
         waited++;
      end
      check("bp_ready_timeout", 32'(in_ready), 32'd1);
      cyc();
      drive(1'b0, 2'd0, '0);
      check("bp_r3",  32'(regs[15:12]), 32'h7);
      check("bp_r2_old", 32'(regs[11:8]), 32'hA);
      cyc();
      check("bp_r2",  32'(regs[11:8]), 32'h9);
      check("bp_empty", 32'(empty), 32'd1);

      // Two writes to R3 retire in order
      hold = 1'b1;
      drive(1'b1, 2'd3, 4'h4); cyc();
      drive(1'b1, 2'd3, 4'hC); cyc();
      drive(1'b0, 2'd0, '0);
      hold = 1'b0;
      cyc();
      check("ord_r3_first", 32'(regs[15:12]), 32'h4);
      check("ord_pend3",    32'(pend[3]),     32'd1);
      cyc();
      check("ord_r3_last",  32'(regs[15:12]), 32'hC);
      check("ord_pend0",    32'(pend),        32'd0);

      // Write to hardwired R0
      drive(1'b1, 2'd0, 4'hF); cyc();
      drive(1'b0, 2'd0, '0);
      check("r0_cnt1", 32'(cnt),  32'd1);
      check("r0_pend", 32'(pend), 32'd0);
      cyc();
      check("r0_cnt0", 32'(cnt),       32'd0);
      check("r0_val",  32'(regs[3:0]), 32'h0);

      // Patterned traffic with simultaneous enqueue/dequeue, model-checked
      for (int i = 0; i < 24; i++) begin
         hold = ((i % 4) == 3);
         drive((i % 3) != 0, 2'(i % 4), DW'(i + 5));
         cyc();
      end
      drive(1'b0, 2'd0, '0);
      hold = 1'b0;
      repeat (3) cyc();

      // Reset mid-operation discards queued writes
      hold = 1'b1;
      drive(1'b1, 2'd1, 4'hE); cyc();
      drive(1'b1, 2'd2, 4'hD); cyc();
      drive(1'b0, 2'd0, '0);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_regs",  32'(regs),     32'h3210);
      check("mid_rst_cnt",   32'(cnt),      32'd0);
      check("mid_rst_ready", 32'(in_ready), 32'd0);
      check("mid_rst_pend",  32'(pend),     32'd0);
      cyc();
      rst_n = 1'b1;
      hold  = 1'b0;
      repeat (4) cyc();
      check("post_rst_regs", 32'(regs), 32'h3210);
      check("post_rst_cnt",  32'(cnt),  32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
